// File: rtl/result_reader.sv
// Streams a block of result-RAM words out in address order, reading two per fetch.
// A 4-word FIFO covers the RAM read latency and downstream stalls.
module result_reader #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32,
    parameter int BASE_ADDR  = 64,
    parameter int NUM_WORDS  = 64
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     start,
    output logic                                     ram_rd_en,
    output logic [ADDR_WIDTH-1:0]                    ram_addrA,
    output logic [ADDR_WIDTH-1:0]                    ram_addrB,
    input  logic [DATA_WIDTH-1:0]                    ram_qA,
    input  logic [DATA_WIDTH-1:0]                    ram_qB,
    output logic [DATA_WIDTH-1:0]                    out_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic                                     out_last,
    output logic [$clog2(NUM_WORDS)-1:0]             out_index,
    output logic                                     busy,
    output logic                                     done,
    output logic [DATA_WIDTH+$clog2(NUM_WORDS)-1:0]  checksum
);

    localparam int IW = $clog2(NUM_WORDS);
    localparam int CW = DATA_WIDTH + IW;
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_WORDS - 1);
    localparam logic [IW-1:0] LAST_PAIR = IW'(NUM_WORDS / 2 - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] BASE_B = ADDR_WIDTH'(BASE_ADDR + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 state;
    logic                   inflight;
    logic [IW-1:0]          fetch_cnt;
    logic [1:0]             wr_ptr;
    logic [1:0]             rd_ptr;
    logic [2:0]             count;
    logic [DATA_WIDTH-1:0]  mem [4];
    logic [3:0]             occupied;
    logic                   xfer;
    logic                   start_go;

    // Slots already spoken for: words held plus the pair still coming back from RAM.
    assign occupied  = {1'b0, count} + {2'b00, inflight, 1'b0};
    assign ram_rd_en = (state == S_FETCH) && (occupied <= 4'd2);

    assign out_valid = (count != 3'd0);
    assign out_data  = mem[rd_ptr];
    assign out_last  = out_valid && (out_index == LAST_IDX);
    assign xfer      = out_valid && out_ready;
    assign start_go  = start && ((state == S_IDLE) || (state == S_DONE));

    // Readout sequencing, address generation and status flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            ram_addrA <= BASE_A;
            ram_addrB <= BASE_B;
            fetch_cnt <= '0;
            inflight  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            inflight <= ram_rd_en;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_FETCH;
                        ram_addrA <= BASE_A;
                        ram_addrB <= BASE_B;
                        fetch_cnt <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (ram_rd_en) begin
                        ram_addrA <= ram_addrA + ADDR_WIDTH'(2);
                        ram_addrB <= ram_addrB + ADDR_WIDTH'(2);
                        fetch_cnt <= fetch_cnt + IW'(1);
                        if (fetch_cnt == LAST_PAIR) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Final word leaving means the FIFO empties at this edge.
                    if (!inflight && xfer && out_last) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // FIFO pointers, occupancy, stream index and running checksum.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            count     <= 3'd0;
            out_index <= '0;
            checksum  <= '0;
        end else if (start_go) begin
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            count     <= 3'd0;
            out_index <= '0;
            checksum  <= '0;
        end else begin
            if (inflight) begin
                wr_ptr <= wr_ptr + 2'd2;
            end
            if (xfer) begin
                rd_ptr    <= rd_ptr + 2'd1;
                out_index <= out_index + IW'(1);
                checksum  <= checksum + CW'(out_data);
            end
            count <= count + (inflight ? 3'd2 : 3'd0) - (xfer ? 3'd1 : 3'd0);
        end
    end

    // Capture the returned pair, port A word ahead of port B word.
    always_ff @(posedge clock) begin
        if (inflight) begin
            mem[wr_ptr]        <= ram_qA;
            mem[wr_ptr + 2'd1] <= ram_qB;
        end
    end

endmodule

// File: doc/result_reader.md
Name: result_reader

Overview:
- Reader side of the result RAM that the matrix-multiply controller fills.
- After the multiply completes, it reads NUM_WORDS result words from BASE_ADDR upward using both RAM ports, two words per fetch.
- Words leave in address order on a valid/ready stream, with a running checksum and a done flag.
- A small internal FIFO absorbs the one-cycle RAM read latency and downstream backpressure.

Parameters:
- ADDR_WIDTH, 7, result RAM address width.
- DATA_WIDTH, 32, result word width.
- BASE_ADDR, 64, first result address. Must be even.
- NUM_WORDS, 64, words per readout. Must be even and ≥2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a readout.
- ram_rd_en  out  1  read enable for both RAM ports.
- ram_addrA  out  ADDR_WIDTH  port A address, always the even word of the pair.
- ram_addrB  out  ADDR_WIDTH  port B address, always ram_addrA+1.
- ram_qA  in  DATA_WIDTH  port A read data, valid the cycle after ram_rd_en.
- ram_qB  in  DATA_WIDTH  port B read data, valid the cycle after ram_rd_en.
- out_data  out  DATA_WIDTH  stream word.
- out_valid  out  1  stream word valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  marks word NUM_WORDS-1.
- out_index  out  $clog2(NUM_WORDS)  index of the current out_data word.
- busy  out  1  readout in progress.
- done  out  1  readout complete; sticky.
- checksum  out  DATA_WIDTH+$clog2(NUM_WORDS)  sum of all accepted words, zero-extended.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE.
  - ram_addrA=BASE_ADDR, ram_addrB=BASE_ADDR+1.
  - ram_rd_en=0, FIFO empty, out_valid=0, out_last=0, out_index=0.
  - busy=0, done=0, checksum=0, fetch and transfer counters 0.
  - Reset mid-readout discards FIFO and in-flight data. No further stream words are produced.
- States:
  - IDLE: start → FETCH. Addresses reload to BASE_ADDR/BASE_ADDR+1; checksum, counters and done clear.
  - FETCH: issues fetches. After the fetch of pair NUM_WORDS/2-1 → DRAIN.
  - DRAIN: no fetches. When the in-flight flag is 0, the FIFO is empty and the last word has transferred → DONE.
  - DONE: done=1. start → FETCH with the same reload as IDLE.
- busy=1 in FETCH and DRAIN only. start is ignored while busy.
- Fetch rule:
  - In FETCH, ram_rd_en=1 only when FIFO free slots − 2×inflight ≥ 2.
  - FIFO depth is 4 words; inflight is a 1-bit flag meaning a fetch was issued last cycle.
  - On each fetch, both addresses advance by 2 the following cycle, modulo 2^ADDR_WIDTH.
- Capture: the cycle after a fetch, ram_qA then ram_qB are pushed into the FIFO (A word first). The FIFO never overflows by construction.
- Stream:
  - out_valid = FIFO non-empty; out_data = FIFO head.
  - A transfer occurs on out_valid & out_ready: pop the head, out_index+1, checksum += out_data.
  - out_last = out_valid & (out_index == NUM_WORDS-1).
  - While out_valid=1 and out_ready=0, out_data/out_index/out_last hold stable.
- Latency: start sampled at cycle 0 → first ram_rd_en at cycle 1 → words pushed at end of cycle 2 → out_valid=1 from cycle 3.
- Throughput: with out_ready held high, one word per cycle after the first.
- done rises the cycle after the out_last transfer and holds until start or reset.
- Simultaneous push and pop in one cycle are both honoured; FIFO count changes by pushes−pops.

Test Plan:
- Full readout, out_ready=1, RAM[a]=3a for a=64..127 → out_data 192,195,…,381 in order.
  - out_valid first at cycle 3; 64 consecutive transfers.
  - out_last only with out_data=381.
  - checksum=18336; done=1 at the cycle after the last transfer; busy=0.
- Backpressure: out_ready=0 for cycles 5–20 → ram_rd_en drops within 2 cycles and the FIFO holds 4 words.
  - out_data/out_index stay stable throughout.
  - After release the sequence resumes with no loss or duplicate; checksum is still 18336.
- out_ready toggling 1,0,1,0 → every second cycle transfers; order, out_last and checksum match the first scenario.
- start pulsed at cycle 10 while busy → ignored; addresses and stream are unaffected.
- reset asserted at cycle 30 mid-readout → all outputs return to reset values asynchronously.
  - A new start after release replays from word 0 with checksum restarted at 0.
- Second start in DONE → done and checksum clear the next cycle; an identical 64-word sequence repeats.
